conv2d_window_gen: RTL
======================

// Module: conv2d_window_gen
// PURPOSE
//  Streaming sliding-window generator placed directly upstream of conv2d_engine.
//  Accepts a raster-order pixel stream (row-major, one pixel per beat) and builds K x K windows.
//  Stores the previous K-1 image rows in line buffers.
//  Emits one window for every position where the kernel fits completely (no padding).
//  The output is shaped to connect directly to conv2d_engine window/win_valid/win_ready.
// PARAMETERS
//  DATA_W  8  bits per channel sample
//  IN_CH   1  channels packed per pixel; a pixel is DATA_W*IN_CH bits, with ch0 in the LSBs
//  K       3  window size (odd, >=2)
//  IMG_W   5  image width in pixels (>=K)
//  IMG_H   5  image height in pixels (>=K)
// PORTS
//  clk        in   1                         single clock; all logic on posedge
//  rst        in   1                         synchronous, active-high reset
//  pix_in     in   DATA_W*IN_CH              input pixel
//  pix_valid  in   1                         pix_in is valid
//  pix_ready  out  1                         block can accept a pixel this cycle
//  window     out  [K-1:0][K-1:0] x DATA_W*IN_CH  window[kr][kc]; kr=0 is the top row, kc=0 is the left column
//  win_valid  out  1                         window is valid
//  win_ready  in   1                         downstream accepts the window
//  win_last   out  1                         qualifies the final window of a frame
//  pix_sof    in   1                         start of frame (only when CONV_WIN_SOF_EN is defined)
// BEHAVIOUR
//  - Clocking and reset: one clock. Reset is synchronous and active-high.
//  - Reset values: win_valid=0, win_last=0, window=0, col=0, row=0.
//  - Line-buffer RAM is not cleared by reset. Stale data is never emitted (see the gating rule below).
//  - pix_ready = !win_valid || win_ready. This is a single-entry output register with a same-cycle refill.
//  - Accept condition: a pixel is accepted when pix_valid && pix_ready.
//  - On accept, the K-1 line buffers (depth IMG_W each, addressed by col) shift vertically, and the
//    K x K shift register shifts left with a new column {linebuf[K-2..0][col], pix_in}.
//  - Window gating: the window for an accepted pixel at (row, col) is loaded into the output
//    register, with win_valid=1 on the next cycle (latency 1). This happens only when
//    row>=K-1 && col>=K-1. Otherwise win_valid stays 0; if win_valid is already 1, it is held/dropped
//    per the handshake rules.
//  - Window contents: bottom-right element = the current pixel; window[kr][kc] = img[row-K+1+kr][col-K+1+kc].
//  - Hold rule: while win_valid && !win_ready, window, win_valid and win_last hold stable, and
//    pix_ready=0. No pixel is lost or duplicated.
//  - Counters: col increments per accept and wraps IMG_W-1 -> 0 with row++.
//    At row=IMG_H-1 && col=IMG_W-1, both wrap to 0, so the next pixel starts a new frame.
//  - win_last = 1 with the window whose centre is (IMG_H-1-K/2, IMG_W-1-K/2), i.e. the last pixel of the frame.
//  - Windows per frame = (IMG_H-K+1)*(IMG_W-K+1).
//  - Back-to-back frames need no gap cycles. The first K-1 rows of a new frame emit nothing.
//  - Reset mid-frame: the partial frame is abandoned, any pending window is dropped, and the next
//    accepted pixel is (0,0).
//  - Widths: pure data movement, with no arithmetic on pixel values.
//    col is $clog2(IMG_W) bits and row is $clog2(IMG_H) bits.
// CONFIGURATION
//  - CONV_WIN_SOF_EN defined:
//    - The pix_sof port exists.
//    - An accepted pixel with pix_sof=1 is treated as (0,0): counters are forced and the pixel is
//      written as col 0 of row 0.
//    - A pending output window is still delivered normally.
//    - pix_sof on a pixel that is already (0,0) has no extra effect.
//  - CONV_WIN_SOF_EN undefined:
//    - There is no pix_sof port.
//    - Frame alignment comes only from reset and counter wrap.
// TESTING
//  - 5x5 image with pixels 1..25 and win_ready=1:
//    - 9 windows are emitted.
//    - First window = {1,2,3 / 6,7,8 / 11,12,13}, valid the cycle after pixel 13 is accepted.
//  - Same stream:
//    - Last window = {13,14,15 / 18,19,20 / 23,24,25} with win_last=1.
//    - win_last=0 on the other 8 windows.
//  - Backpressure: win_ready=0 for 3 cycles while a window is pending:
//    - The window is stable and pix_ready=0 throughout.
//    - The full sequence of 9 windows still matches the golden model.
//  - Two frames back-to-back (1..25 then 101..125):
//    - 18 windows in total.
//    - The second frame's first window = {101,102,103 / 106,107,108 / 111,112,113}.
//  - Reset after 12 pixels are accepted, then a full frame:
//    - win_valid=0 on the cycle after rst.
//    - Exactly 9 correct windows follow.
//  - CONV_WIN_SOF_EN: 7 junk pixels, then 1..25 with pix_sof on pixel 1 -> windows identical to the first test.

Source files
------------

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen: raster-stream K x K sliding-window generator; CONV_WIN_SOF_EN adds pix_sof frame realignment
module conv2d_window_gen #(
  parameter int DATA_W = 8,
  parameter int IN_CH = 1,
  parameter int K = 3,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_W*IN_CH-1:0] pix_in,
  input  logic pix_valid,
  output logic pix_ready,
  output logic [K-1:0][K-1:0][DATA_W*IN_CH-1:0] window,
  output logic win_valid,
  input  logic win_ready,
  output logic win_last
`ifdef CONV_WIN_SOF_EN
  ,
  input  logic pix_sof
`endif
);
  localparam int PW = DATA_W*IN_CH;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H-1);
  localparam logic [CW-1:0] COL_MIN = CW'(K-1);
  localparam logic [RW-1:0] ROW_MIN = RW'(K-1);
  logic [PW-1:0] lb_q [K-1][IMG_W];
  logic [K-1:0][K-2:0][PW-1:0] sr_q, sr_d;
  logic [K-1:0][K-1:0][PW-1:0] win_nx, window_q, window_d;
  logic [CW-1:0] col_q, col_d, col_e;
  logic [RW-1:0] row_q, row_d, row_e;
  logic win_valid_q, win_valid_d, win_last_q, win_last_d, acc, gate, sof;
`ifdef CONV_WIN_SOF_EN
  assign sof = pix_sof;
`else
  assign sof = 1'b0;
`endif
  assign pix_ready = !win_valid_q || win_ready;
  assign window = window_q;
  assign win_valid = win_valid_q;
  assign win_last = win_last_q;
  // sr_q keeps only the K-1 rightmost columns of the last window; the new column completes it
  always_comb begin
    acc = pix_valid && pix_ready;
    col_e = sof ? '0 : col_q;
    row_e = sof ? '0 : row_q;
    gate = acc && row_e >= ROW_MIN && col_e >= COL_MIN;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++)
        win_nx[r][c] = sr_q[r][c];
    for (int r = 0; r < K-1; r++)
      win_nx[r][K-1] = lb_q[K-2-r][col_e];
    win_nx[K-1][K-1] = pix_in;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++)
        sr_d[r][c] = acc ? win_nx[r][c+1] : sr_q[r][c];
    col_d = !acc ? col_q : (col_e == COL_MAX ? '0 : col_e + 1'b1);
    row_d = !acc ? row_q : (col_e != COL_MAX ? row_e : (row_e == ROW_MAX ? '0 : row_e + 1'b1));
    win_valid_d = acc ? gate : win_valid_q && !win_ready;
    win_last_d = acc ? gate && row_e == ROW_MAX && col_e == COL_MAX : win_last_q && !win_ready;
    window_d = gate ? win_nx : window_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      win_valid_q <= 1'b0;
      win_last_q <= 1'b0;
      window_q <= '0;
      sr_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q <= win_last_d;
      window_q <= window_d;
      sr_q <= sr_d;
    end
  end
  // line buffers hold raw RAM contents; the row/col gate keeps stale entries from being emitted
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_q[0][col_e] <= pix_in;
      for (int i = 1; i < K-1; i++)
        lb_q[i][col_e] <= lb_q[i-1][col_e];
    end
  end
endmodule
